// File: rtl/tetris_pkg.sv
// Shared Tetris board geometry, VGA commit timing and scheduler state encoding.
package tetris_pkg;
    localparam int COLS     = 10;
    localparam int ROWS     = 24;
    localparam int BOARD_W  = COLS * ROWS;
    localparam int ROW_W    = 5;
    localparam int H_TOTAL  = 800;
    localparam int H_LAST   = 799;
    localparam int V_COMMIT = 514;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time gets the grant.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);
    logic last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        last_d = last_q;
        if (advance_i && (req_i != 2'b00))
            last_d = grant_o[1];
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/board_frame_scheduler.sv
// Shadow Tetris board fed by two row writers plus a clear; the displayed copy only
// changes at the end of the last active line, so a frame never shows a half-applied update.
module board_frame_scheduler
    import tetris_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            counter_x,
    input  logic [9:0]            counter_y,
    input  logic                  clr_req,
    output logic                  clr_ack,
    input  logic [1:0]            wr_valid,
    input  logic [ROW_W-1:0]      wr_row0,
    input  logic [ROW_W-1:0]      wr_row1,
    input  logic [COLS-1:0]       wr_data0,
    input  logic [COLS-1:0]       wr_data1,
    input  logic [COLS-1:0]       wr_mask0,
    input  logic [COLS-1:0]       wr_mask1,
    output logic [1:0]            wr_ready,
    output logic                  wr_err,
    output logic [BOARD_W-1:0]    data,
    output logic                  frame_tick
);
    sched_state_t         state_q, state_d;
    logic [1:0]           gnt_q, gnt_d, arb_gnt;
    logic [BOARD_W-1:0]   shadow_q, shadow_d, data_q, data_d;
    logic                 dirty_q, dirty_d, tick_q, tick_d;
    logic                 advance, commit, row_ok;
    logic [ROW_W-1:0]     sel_row;
    logic [COLS-1:0]      sel_data, sel_mask;

    assign advance = (state_q == IDLE) && !clr_req && (wr_valid != 2'b00);
    assign commit  = (counter_x == 10'(H_LAST)) && (counter_y == 10'(V_COMMIT));

    rr_arbiter2 u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (wr_valid),
        .advance_i (advance),
        .grant_o   (arb_gnt)
    );

    // Payload is read during WRITE; the requester holds it until it sees ready.
    assign sel_row  = gnt_q[1] ? wr_row1  : wr_row0;
    assign sel_data = gnt_q[1] ? wr_data1 : wr_data0;
    assign sel_mask = gnt_q[1] ? wr_mask1 : wr_mask0;
    assign row_ok   = sel_row < ROW_W'(ROWS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            shadow_q <= '0;
            data_q   <= '0;
            dirty_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            dirty_q  <= dirty_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (wr_valid != 2'b00) begin
                    state_d = WRITE;
                    gnt_d   = arb_gnt;
                end
            end
            WRITE:   state_d = IDLE;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state_q == WRITE) ? gnt_q : 2'b00;
        wr_err   = (state_q == WRITE) && !row_ok;
        clr_ack  = (state_q == CLEAR);
    end

    // Commit copies the pre-update shadow; a same-cycle update keeps dirty set for next frame.
    always_comb begin
        shadow_d = shadow_q;
        data_d   = data_q;
        dirty_d  = dirty_q;
        tick_d   = commit;
        if (commit) begin
            if (dirty_q) data_d = shadow_q;
            dirty_d = 1'b0;
        end
        if (state_q == WRITE && row_ok) begin
            for (int r = 0; r < ROWS; r++) begin
                if (sel_row == ROW_W'(r))
                    shadow_d[r*COLS +: COLS] = (shadow_q[r*COLS +: COLS] & ~sel_mask) |
                                               (sel_data & sel_mask);
            end
            dirty_d = 1'b1;
        end else if (state_q == CLEAR) begin
            shadow_d = '0;
            dirty_d  = 1'b1;
        end
    end

    assign data       = data_q;
    assign frame_tick = tick_q;
endmodule
